// File: rtl/fp_resp_buffer.sv
// In-order response buffer for fp execute completions: FIFO with valid/accept
// return port, sticky exception flag accumulator and sticky overflow. Optional FP_CANON_NAN_EN.
module fp_resp_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         exe_valid,
  input  logic [31:0]                  exe_result,
  input  logic [4:0]                   exe_flags,
  input  logic [TAG_W-1:0]             exe_tag,
  output logic                         exe_ready,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_result,
  output logic [4:0]                   rsp_flags,
  output logic [TAG_W-1:0]             rsp_tag,
  input  logic                         rsp_accept,
  output logic [4:0]                   acc_flags,
  input  logic                         acc_clear,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [4:0]         acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               full_c, push_c, pop_c;
  logic [31:0]        wr_result_c;
  entry_t             head_c;

  // NaN canonicalisation applies only to what gets stored, never to flags
  always_comb begin
    wr_result_c = exe_result;
`ifdef FP_CANON_NAN_EN
    if ((exe_result[30:23] == 8'hFF) && (exe_result[22:0] != 23'd0)) begin
      wr_result_c = 32'h7FC0_0000;
    end
`endif
  end

  always_comb begin
    full_c = (count_q == CNT_W'(DEPTH));
    push_c = exe_valid && !full_c;
    pop_c  = (count_q != '0) && rsp_accept;
    head_c = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A dropped completion is sticky even if a pop frees a slot this cycle
    if (exe_valid && full_c) ovf_d = 1'b1;
    if (pop_c) begin
      acc_d = (acc_clear ? 5'd0 : acc_q) | head_c.flags;
    end else if (acc_clear) begin
      acc_d = 5'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage needs no reset; validity comes from count
  always_ff @(posedge clock) begin
    if (push_c && !reset) begin
      mem_q[wr_ptr_q] <= '{result: wr_result_c, flags: exe_flags, tag: exe_tag};
    end
  end

  always_comb begin
    exe_ready  = !full_c;
    rsp_valid  = (count_q != '0);
    rsp_result = rsp_valid ? head_c.result : 32'd0;
    rsp_flags  = rsp_valid ? head_c.flags  : 5'd0;
    rsp_tag    = rsp_valid ? head_c.tag    : TAG_W'(0);
    acc_flags  = acc_q;
    count      = count_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_fp_resp_buffer.sv
// Bench for fp_resp_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fp_resp_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               exe_valid;
  logic [31:0]        exe_result;
  logic [4:0]         exe_flags;
  logic [TAG_W-1:0]   exe_tag;
  logic               exe_ready;
  logic               rsp_valid;
  logic [31:0]        rsp_result;
  logic [4:0]         rsp_flags;
  logic [TAG_W-1:0]   rsp_tag;
  logic               rsp_accept;
  logic [4:0]         acc_flags;
  logic               acc_clear;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  fp_resp_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .exe_valid(exe_valid), .exe_result(exe_result), .exe_flags(exe_flags), .exe_tag(exe_tag),
    .exe_ready(exe_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .rsp_accept(rsp_accept),
    .acc_flags(acc_flags), .acc_clear(acc_clear),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of stored responses plus sticky state
  typedef struct packed {
    logic [31:0]      r;
    logic [4:0]       f;
    logic [TAG_W-1:0] t;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_acc;
  bit         m_ovf;

  function automatic logic [31:0] stored_value(input logic [31:0] r);
`ifdef FP_CANON_NAN_EN
    if (r[30:23] == 8'hFF && r[22:0] != 0) return 32'h7FC00000;
`endif
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_acc = 5'd0;
      m_ovf = 1'b0;
    end else begin
      int n;
      ent_t e;
      n = mq.size();
      if (exe_valid && n == DEPTH) m_ovf = 1'b1;
      if (rsp_accept && n > 0) begin
        e = mq.pop_front();
        m_acc = (acc_clear ? 5'd0 : m_acc) | e.f;
      end else if (acc_clear) begin
        m_acc = 5'd0;
      end
      if (exe_valid && n < DEPTH) mq.push_back('{stored_value(exe_result), exe_flags, exe_tag});
    end
  end

  always @(negedge clock) begin
    if (run_chk) begin
      bit v;
      v = (mq.size() != 0);
      chk("m_rsp_valid", rsp_valid, v);
      chk("m_rsp_result", rsp_result, v ? mq[0].r : 32'd0);
      chk("m_rsp_flags", rsp_flags, v ? mq[0].f : 5'd0);
      chk("m_rsp_tag", rsp_tag, v ? mq[0].t : 4'd0);
      chk("m_count", count, mq.size());
      chk("m_exe_ready", exe_ready, mq.size() != DEPTH);
      chk("m_acc_flags", acc_flags, m_acc);
      chk("m_overflow", overflow, m_ovf);
    end
  end

  // One clock of stimulus; returns just after the edge that consumed it
  task automatic step(input bit v, input logic [31:0] r, input logic [4:0] f,
                      input logic [TAG_W-1:0] t, input bit acc, input bit clr);
    @(negedge clock);
    exe_valid = v; exe_result = r; exe_flags = f; exe_tag = t;
    rsp_accept = acc; acc_clear = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    exe_valid = 1'b0; rsp_accept = 1'b0; acc_clear = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    exe_valid = 1'b0; exe_result = '0; exe_flags = '0; exe_tag = '0;
    rsp_accept = 1'b0; acc_clear = 1'b0;
    @(posedge clock);
    #1;
    run_chk = 1'b1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", exe_ready, 1);
    chk("rst_acc", acc_flags, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_result", rsp_result, 0);
    @(negedge clock);
    reset = 1'b0;

    // Single push then accept
    step(1, 32'h3F800000, 5'h00, 4'd1, 0, 0);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_result", rsp_result, 32'h3F800000);
    chk("t1_tag", rsp_tag, 1);
    chk("t1_count", count, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_valid_after", rsp_valid, 0);
    chk("t1_count_after", count, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_empty_accept", count, 0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 4; i++) step(1, 32'h40000000 + i, 5'h00, 4'(2 + i), 0, 0);
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", exe_ready, 0);
    step(1, 32'hDEADBEEF, 5'h1F, 4'd6, 0, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_ovf", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_tag", rsp_tag, 2 + i);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("t2_drained", count, 0);
    chk("t2_ovf_sticky", overflow, 1);

    // Reset mid-operation discards entries
    for (int i = 0; i < 3; i++) step(1, 32'h1000 + i, 5'h00, 4'(i), 0, 0);
    do_reset();
    chk("t3_rst_count", count, 0);
    chk("t3_rst_valid", rsp_valid, 0);
    chk("t3_rst_ovf", overflow, 0);

    // Push while full with simultaneous accept: still dropped
    for (int i = 0; i < 4; i++) step(1, 32'h2000 + i, 5'h00, 4'(7 + i), 0, 0);
    step(1, 32'h2FFF, 5'h00, 4'd11, 1, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_count", count, 3);
    chk("t4_head_tag", rsp_tag, 8);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("t4_empty", count, 0);

    // Flag accumulation and clear-then-accumulate
    do_reset();
    step(1, 32'h1, 5'h01, 4'd1, 0, 0);
    step(1, 32'h2, 5'h10, 4'd2, 0, 0);
    step(1, 32'h3, 5'h04, 4'd3, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t5_acc_11", acc_flags, 5'h11);
    step(0, 0, 0, 0, 1, 1);
    chk("t5_acc_04", acc_flags, 5'h04);
    step(0, 0, 0, 0, 0, 1);
    chk("t5_acc_clr", acc_flags, 0);

    // NaN canonicalisation / bit-exact storage, infinity untouched
    step(1, 32'hFFC12345, 5'h10, 4'd4, 0, 0);
`ifdef FP_CANON_NAN_EN
    chk("t6_nan", rsp_result, 32'h7FC00000);
`else
    chk("t6_nan", rsp_result, 32'hFFC12345);
`endif
    chk("t6_nan_flags", rsp_flags, 5'h10);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'h7F800000, 5'h00, 4'd5, 0, 0);
    chk("t6_inf", rsp_result, 32'h7F800000);
    step(0, 0, 0, 0, 1, 0);

    // Sustained push+accept with pointer wrap
    do_reset();
    step(1, 32'h5000, 5'h00, 4'd0, 1, 0);
    chk("t7_first", count, 1);
    for (int i = 1; i < 20; i++) begin
      step(1, 32'h5000 + i, 5'h00, 4'(i), 1, 0);
      chk("t7_count", count, 1);
      chk("t7_result", rsp_result, 32'h5000 + i);
    end
    chk("t7_ovf", overflow, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t7_end", count, 0);

    step(0, 0, 0, 0, 0, 0);
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
